led_status_scheduler: RTL
=========================

Name: led_status_scheduler

Overview:
- Time-shares the KC705's 8 GPIO LEDs between up to NUM_SRC status requesters, such as a board test, a PLL lock monitor or a rasterizer debug block.
- Each active requester gets a fixed dwell slot, chosen round-robin. Slots are separated by a short blank gap so an observer can tell them apart.
- When no requester is active, a heartbeat pattern runs.
- The block sits between the status producers and the gpio_led pads, in the 200 MHz system clock domain.

Parameters:
- NUM_SRC, 4: number of requesters (2..8).
- DWELL_CYCLES, 100_000_000: slot length in clocks (0.5 s at 200 MHz).
- GAP_CYCLES, 20_000_000: blank interval between slots, in clocks.
- BLINK_LOG2, 24: free-running counter bit used as the blink phase.
- HB_LOG2, 27: free-running counter bit used as the heartbeat.

Ports:
- clk_200mhz  in  1  system clock. The single clock for the block.
- rst_n  in  1  asynchronous, active-low reset.
- src_valid  in  NUM_SRC  per-source request (level). Bit i high means source i wants display time.
- src_pattern  in  NUM_SRC*8  per-source LED pattern. Source i occupies bits [8i+7:8i]. Sampled live.
- src_blink  in  NUM_SRC  per-source blink enable.
- gpio_led  out  8  registered LED drive, active-high.
- active_valid  out  1  high while in SHOW.
- active_src  out  $clog2(NUM_SRC)  index of the source currently shown.
- slot_done  out  1  one-cycle pulse when a SHOW slot ends, for either reason.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; gpio_led=0; active_valid=0; active_src=0; slot_done=0.
  - Free-running counter=0; dwell/gap counter=0.
  - last_grant=NUM_SRC-1, so the first grant goes to source 0.
- Free-running counter: width HB_LOG2+1, increments every cycle, wraps silently.
  - blink_phase = counter[BLINK_LOG2].
  - hb = counter[HB_LOG2].
- Round-robin pick (combinational): the first i with src_valid[i]=1, searching from last_grant+1 upward and wrapping modulo NUM_SRC. "none" if src_valid is 0.
- State machine (IDLE, SHOW, GAP):
  - IDLE → SHOW when the pick is not "none". Same edge: active_src=pick, last_grant=pick, dwell counter=DWELL_CYCLES-1.
  - SHOW ends in either of two ways; both go to GAP with gap counter=GAP_CYCLES-1 and slot_done=1 for one cycle:
    - Early end: src_valid[active_src] drops.
    - Normal end: dwell counter reaches 0 (the counter decrements each cycle otherwise).
    - If both happen in the same cycle, it counts as one end with one slot_done pulse.
  - GAP: the gap counter decrements. At 0:
    - if the pick is not "none", go → SHOW (load as above);
    - otherwise go → IDLE.
    - A single persistent source is therefore re-granted after every gap.
  - Requests that rise during SHOW or GAP never pre-empt. They are considered only at the next decision point.
- Outputs (registered, computed from the current state, one clock after the state register):
  - IDLE: gpio_led = {7'b0, hb}.
  - SHOW: gpio_led = pattern[active_src] & {8{~src_blink[active_src] | blink_phase}}.
  - GAP: gpio_led = 8'h00.
  - active_valid = (state==SHOW), registered alongside gpio_led.
  - active_src holds its last value in GAP and IDLE.
- Latency: src_valid rises at edge 0 (from IDLE) → state=SHOW after edge 1 → gpio_led and active_valid show the pattern after edge 2.
- Reset mid-slot: everything returns to its reset values immediately (async). There is no resume, and the round-robin pointer restarts at source 0.
- Width rule: the dwell and gap counters are $clog2(max(DWELL_CYCLES,GAP_CYCLES)) bits. Both parameters must be ≥1.

Decomposition:
- Package led_sched_pkg holds:
  - the state enum (ST_IDLE, ST_SHOW, ST_GAP);
  - localparam LED_W=8;
  - a helper function for the source-index width.
- Sub-module led_rr_pick: a combinational round-robin search. Inputs are req[NUM_SRC] and last[idx]; outputs are pick[idx] and pick_valid.

Test Plan:
Bench parameters: NUM_SRC=4, DWELL=16, GAP=4, BLINK_LOG2=2, HB_LOG2=4.
1. Reset with no requests:
   - gpio_led=8'h00 during reset.
   - After release, gpio_led[0] toggles every 16 clocks and the other bits stay 0.
   - active_valid=0 throughout.
2. Single source: src_valid=4'b0100, pattern2=8'hA5, blink=0.
   - Grant 2; gpio_led=A5 for 16 cycles; slot_done pulses once.
   - Then 4 cycles of 00, then A5 again, repeating.
3. Round-robin: src_valid=4'b1011 with patterns 11/22/--/88.
   - Slots show 11, 22, 88, 11… in that order, with a 4-cycle blank between each.
   - active_src follows 0, 1, 3, 0.
4. Early termination: drop src_valid[1] 5 cycles into its slot.
   - slot_done pulses the next cycle; GAP starts early; the next grant goes to source 3.
5. Blink: source 0 with pattern FF and blink=1.
   - gpio_led alternates between FF and 00 every 4 cycles, in phase with counter[2], for the whole slot.
6. Async reset mid-SHOW: assert rst_n=0 during source 3's slot.
   - Outputs clear within the same cycle.
   - After release with all requests still high, the first grant goes to source 0.

Source files
------------

// File: rtl/led_sched_pkg.sv
// Shared types and sizing helpers for the LED status scheduler.
`timescale 1ns/1ps
package led_sched_pkg;

    localparam int LED_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_t;

    // Bits needed to index n sources; never narrower than one bit.
    function automatic int src_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Dwell/gap counter width, sized by the larger of the two loads.
    function automatic int slot_cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/led_rr_pick.sv
// Combinational round-robin search starting one past the last grant.
`timescale 1ns/1ps
module led_rr_pick
    import led_sched_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = src_idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   pick,
    output logic               pick_valid
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        // k = NUM_SRC lands back on last itself, so a lone requester is re-granted.
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand     = (int'(last) + k) % NUM_SRC;
            cand_idx = IDX_W'(cand);
            if (!pick_valid && req[cand_idx]) begin
                pick       = cand_idx;
                pick_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_status_scheduler.sv
// Time-shares the board LEDs between status requesters in round-robin dwell
// slots separated by blank gaps; a heartbeat runs when nobody is asking.
`timescale 1ns/1ps
module led_status_scheduler
    import led_sched_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int GAP_CYCLES   = 20_000_000,
    parameter int BLINK_LOG2   = 24,
    parameter int HB_LOG2      = 27,
    parameter int IDX_W        = src_idx_w(NUM_SRC)
) (
    input  logic                     clk_200mhz,
    input  logic                     rst_n,
    // src_valid is a level request with no ready: a source holds it high for as
    // long as it wants display time and is only looked at at decision points.
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [NUM_SRC*LED_W-1:0] src_pattern,
    input  logic [NUM_SRC-1:0]       src_blink,
    output logic [LED_W-1:0]         gpio_led,
    output logic                     active_valid,
    output logic [IDX_W-1:0]         active_src,
    output logic                     slot_done,
    output sched_state_t             dbg_state
);

    localparam int CNT_W = slot_cnt_w(DWELL_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    sched_state_t       state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   last_grant, last_grant_nxt;
    logic [IDX_W-1:0]   active_src_nxt;
    logic               slot_done_nxt;
    logic [HB_LOG2:0]   fr_cnt;
    logic [IDX_W-1:0]   pick;
    logic               pick_valid;
    logic [LED_W-1:0]   pat_arr [NUM_SRC];

    wire blink_phase = fr_cnt[BLINK_LOG2];
    wire hb          = fr_cnt[HB_LOG2];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign pat_arr[g] = src_pattern[g*LED_W +: LED_W];
    end

    led_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (src_valid),
        .last       (last_grant),
        .pick       (pick),
        .pick_valid (pick_valid)
    );

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        active_src_nxt = active_src;
        last_grant_nxt = last_grant;
        slot_done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nxt      = ST_SHOW;
                    active_src_nxt = pick;
                    last_grant_nxt = pick;
                    cnt_nxt        = DWELL_LOAD;
                end
            end
            ST_SHOW: begin
                // A dropped request and an expired dwell collapse into one end.
                if (!src_valid[active_src] || cnt == '0) begin
                    state_nxt     = ST_GAP;
                    cnt_nxt       = GAP_LOAD;
                    slot_done_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    if (pick_valid) begin
                        state_nxt      = ST_SHOW;
                        active_src_nxt = pick;
                        last_grant_nxt = pick;
                        cnt_nxt        = DWELL_LOAD;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_200mhz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_grant <= IDX_W'(NUM_SRC - 1);
            active_src <= '0;
            slot_done  <= 1'b0;
            fr_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_grant <= last_grant_nxt;
            active_src <= active_src_nxt;
            slot_done  <= slot_done_nxt;
            fr_cnt     <= fr_cnt + 1'b1;
        end
    end

    // LED drive follows the registered state, so it trails the FSM by one clock.
    always_ff @(posedge clk_200mhz or negedge rst_n) begin
        if (!rst_n) begin
            gpio_led     <= '0;
            active_valid <= 1'b0;
        end else begin
            active_valid <= (state == ST_SHOW);
            case (state)
                ST_IDLE: gpio_led <= {{(LED_W-1){1'b0}}, hb};
                ST_SHOW: gpio_led <= pat_arr[active_src]
                                     & {LED_W{~src_blink[active_src] | blink_phase}};
                default: gpio_led <= '0;
            endcase
        end
    end

    assign dbg_state = state;

endmodule
